snd_cmd_sender: RTL

SND_CMD_SENDER -- requirements
Module: snd_cmd_sender

---
 rtl/snd_cmd_sender.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/snd_cmd_sender.sv
// Sound command sender: queues main-CPU command bytes in a small FIFO and
// replays each one to the sound board as a setup / strobe / gap sequence.
module snd_cmd_sender #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 8,
  parameter int GAP_CYC   = 4096
) (
  input  logic       clk8M,
  input  logic       reset,
  input  logic       cpu_cs_snd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_do,
  input  logic       flush,
  output logic [7:0] sndno,
  output logic       sndstart,
  output logic [4:0] fifo_cnt,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LD  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ASSERT, GAP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      sndno_q, sndno_d;
  logic            sndstart_q, sndstart_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            wr_lvl_q, wr_lvl_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic wr_event, full, pop, push;

  always_comb begin
    wr_lvl_d = cpu_cs_snd & cpu_wr;
    wr_event = wr_lvl_d & ~wr_lvl_q;
    full     = (count_q == 5'(DEPTH));
    // Pop only from the registered count, so a fresh byte waits one edge.
    pop      = (state_q == IDLE) && (count_q != 5'd0) && !flush;
    push     = wr_event && !flush && (!full || pop);

    state_d    = state_q;
    cnt_d      = cnt_q;
    sndno_d    = sndno_q;
    sndstart_d = sndstart_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    mem_d      = mem_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          sndno_d  = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 1'b1;
          cnt_d    = SETUP_LD;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 16'd0) begin
          sndstart_d = 1'b1;
          cnt_d      = HOLD_LD;
          state_d    = ASSERT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ASSERT: begin
        if (cnt_q == 16'd0) begin
          sndstart_d = 1'b0;
          cnt_d      = GAP_LD;
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = cpu_do;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // Flush wins over everything queue-related; the in-flight pulse is untouched.
    if (flush) begin
      count_d  = 5'd0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ovf_d    = 1'b0;
    end else if (wr_event && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      sndno_q    <= 8'h00;
      sndstart_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 5'd0;
      ovf_q      <= 1'b0;
      // Pretend the strobe was already high so a level held through reset is ignored.
      wr_lvl_q   <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sndno_q    <= sndno_d;
      sndstart_q <= sndstart_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      wr_lvl_q   <= wr_lvl_d;
      mem_q      <= mem_d;
    end
  end

  assign sndno    = sndno_q;
  assign sndstart = sndstart_q;
  assign fifo_cnt = count_q;
  assign overflow = ovf_q;
  assign busy     = (count_q != 5'd0) || (state_q != IDLE);

endmodule
